rice_core_div_issue: RTL and testbench

Issue/return controller sitting directly upstream of the core divider (rice_core_div) in the execute stage. It accepts one divide request at a time from the execute pipeline over a valid/ready handshake. It latches the operands, operation and destination tag, and drives them to the divider unchanged until the divider reports its result. It then returns the result to writeback over a valid/ready handshake, and handles pipeline flushes safely while a divide is in flight.

---
 rtl/rice_core_pkg.sv | 19 +
 rtl/rice_core_div_issue.sv | 124 ++++++++++++
 tb/tb_rice_core_div_issue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rice_core_pkg.sv
// Shared types for the rice core execute stage: divider operation encoding
// and the divider issue/return controller state.
package rice_core_pkg;

   typedef enum logic [3:0] {
      DIV_OP_DIV  = 4'b0001,
      DIV_OP_DIVU = 4'b0010,
      DIV_OP_REM  = 4'b0100,
      DIV_OP_REMU = 4'b1000
   } rice_core_div_operation;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN,
      DONE
   } rice_core_div_issue_state;

endpackage

// File: rtl/rice_core_div_issue.sv
// Issue/return controller in front of rice_core_div: holds one divide request,
// keeps the divider fed until it answers, and returns the result to writeback.
module rice_core_div_issue
   import rice_core_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,

   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic [XLEN-1:0]        i_req_rs1,
   input  logic [XLEN-1:0]        i_req_rs2,
   input  rice_core_div_operation i_req_op,
   input  logic [TAG_WIDTH-1:0]   i_req_rd,

   output logic                   o_div_valid,
   output logic [XLEN-1:0]        o_div_rs1,
   output logic [XLEN-1:0]        o_div_rs2,
   output rice_core_div_operation o_div_op,
   input  logic                   i_div_result_valid,
   input  logic [XLEN-1:0]        i_div_result,

   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [XLEN-1:0]        o_rsp_result,
   output logic [TAG_WIDTH-1:0]   o_rsp_rd
);

   rice_core_div_issue_state state_q, state_d;

   logic [XLEN-1:0]        rs1_q, rs1_d;
   logic [XLEN-1:0]        rs2_q, rs2_d;
   rice_core_div_operation op_q, op_d;
   logic [TAG_WIDTH-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]        result_q, result_d;

   // NOTE: every output and _d signal gets a default before the case so no
   // path through the block can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      op_d        = op_q;
      rd_d        = rd_q;
      result_d    = result_q;
      o_req_ready = 1'b0;
      o_div_valid = 1'b0;
      o_rsp_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid && !i_flush) begin
               rs1_d   = i_req_rs1;
               rs2_d   = i_req_rs2;
               op_d    = i_req_op;
               rd_d    = i_req_rd;
               state_d = BUSY;
            end
         end
         BUSY: begin
            o_div_valid = 1'b1;
            if (i_div_result_valid) begin
               if (i_flush) begin
                  state_d = IDLE;
               end else begin
                  result_d = i_div_result;
                  state_d  = DONE;
               end
            end else if (i_flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // The divider only counts while valid is high, so it must be run
            // to completion before it can accept a new operation.
            o_div_valid = 1'b1;
            if (i_div_result_valid) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            o_rsp_valid = 1'b1;
            if (i_flush || i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the data registers carry no reset; they are only observed while
   // the FSM says they hold a live request or response.
   always_ff @(posedge i_clk) begin
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
   end

   assign o_div_rs1    = rs1_q;
   assign o_div_rs2    = rs2_q;
   assign o_div_op     = op_q;
   assign o_rsp_result = result_q;
   assign o_rsp_rd     = rd_q;

endmodule

// File: tb/tb_rice_core_div_issue.sv
// Self-checking bench for rice_core_div_issue with a behavioural divider
// model and a reference for RISC-V divide semantics and latency.
module tb_rice_core_div_issue;
   import rice_core_pkg::*;

   localparam int XLEN = 32;
   localparam int TAG_WIDTH = 5;

   logic                   i_clk;
   logic                   i_rst_n;
   logic                   i_flush;
   logic                   i_req_valid;
   logic                   o_req_ready;
   logic [XLEN-1:0]        i_req_rs1;
   logic [XLEN-1:0]        i_req_rs2;
   rice_core_div_operation i_req_op;
   logic [TAG_WIDTH-1:0]   i_req_rd;
   logic                   o_div_valid;
   logic [XLEN-1:0]        o_div_rs1;
   logic [XLEN-1:0]        o_div_rs2;
   rice_core_div_operation o_div_op;
   logic                   i_div_result_valid;
   logic [XLEN-1:0]        i_div_result;
   logic                   o_rsp_valid;
   logic                   i_rsp_ready;
   logic [XLEN-1:0]        o_rsp_result;
   logic [TAG_WIDTH-1:0]   o_rsp_rd;

   int checks = 0;
   int errors = 0;

   rice_core_div_issue #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH)) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_flush            (i_flush),
      .i_req_valid        (i_req_valid),
      .o_req_ready        (o_req_ready),
      .i_req_rs1          (i_req_rs1),
      .i_req_rs2          (i_req_rs2),
      .i_req_op           (i_req_op),
      .i_req_rd           (i_req_rd),
      .o_div_valid        (o_div_valid),
      .o_div_rs1          (o_div_rs1),
      .o_div_rs2          (o_div_rs2),
      .o_div_op           (o_div_op),
      .i_div_result_valid (i_div_result_valid),
      .i_div_result       (i_div_result),
      .o_rsp_valid        (o_rsp_valid),
      .i_rsp_ready        (i_rsp_ready),
      .o_rsp_result       (o_rsp_result),
      .o_rsp_rd           (o_rsp_rd)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // RISC-V M-extension divide semantics, including /0 and overflow.
   function automatic logic [XLEN-1:0] ref_div(input rice_core_div_operation op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      logic [XLEN-1:0] r;
      case (op)
         DIV_OP_DIVU: r = (b == 0) ? '1 : a / b;
         DIV_OP_REMU: r = (b == 0) ? a : a % b;
         DIV_OP_DIV:  r = (b == 0) ? '1 : XLEN'(sa / sb);
         default:     r = (b == 0) ? a : XLEN'(sa % sb);
      endcase
      return r;
   endfunction

   // Divider cycles with valid high, including the result cycle: two setup
   // cycles plus one per significant dividend bit (sign bits skipped).
   function automatic int ref_lat(input rice_core_div_operation op, input logic [XLEN-1:0] a);
      logic [XLEN-1:0] m = a;
      int bits = 1;
      if ((op == DIV_OP_DIV || op == DIV_OP_REM) && a[XLEN-1]) m = ~a;
      for (int i = 0; i < XLEN; i++) if (m[i]) bits = i + 1;
      return bits + 2;
   endfunction

   // Behavioural divider: counts only while valid is high.
   int div_cnt;
   assign i_div_result_valid = o_div_valid && (div_cnt == ref_lat(o_div_op, o_div_rs1) - 1);
   assign i_div_result       = ref_div(o_div_op, o_div_rs1, o_div_rs2);

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)         div_cnt <= 0;
      else if (o_div_valid) div_cnt <= i_div_result_valid ? 0 : div_cnt + 1;
      else                  div_cnt <= 0;
   end

   // Interface monitor: operand stability, valid drop after result, bound.
   bit                     res_prev, dv_prev, div_changed, rsp_seen;
   logic [XLEN-1:0]        p_rs1, p_rs2;
   rice_core_div_operation p_op;

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         res_prev    = 0;
         dv_prev     = 0;
         div_changed = 0;
      end else begin
         if (res_prev) check("div_valid_drop", 64'(o_div_valid), 64'(0));
         if (o_div_valid && dv_prev && (o_div_rs1 !== p_rs1 || o_div_rs2 !== p_rs2 || o_div_op !== p_op))
            div_changed = 1;
         if (i_div_result_valid) begin
            check("div_stable", 64'(div_changed), 64'(0));
            check("div_lat_bound", 64'(div_cnt + 1 <= XLEN + 2), 64'(1));
            div_changed = 0;
         end
         if (o_rsp_valid) rsp_seen = 1;
         res_prev = i_div_result_valid;
         dv_prev  = o_div_valid;
         p_rs1    = o_div_rs1;
         p_rs2    = o_div_rs2;
         p_op     = o_div_op;
      end
   end

   task automatic accept(input rice_core_div_operation op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_WIDTH-1:0] rd);
      @(negedge i_clk);
      check("req_ready_idle", 64'(o_req_ready), 64'(1));
      i_req_valid = 1'b1;
      i_req_op    = op;
      i_req_rs1   = a;
      i_req_rs2   = b;
      i_req_rd    = rd;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 1'b0;
      i_req_rs1   = $urandom;
      i_req_rs2   = $urandom;
   endtask

   task automatic run_op(input rice_core_div_operation op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_WIDTH-1:0] rd,
                         input logic [XLEN-1:0] exp_res, input int bp, input int exp_lat);
      int n = 0;
      accept(op, a, b, rd);
      while (!o_rsp_valid && n < 100) begin
         @(posedge i_clk);
         n++;
         @(negedge i_clk);
      end
      if (!o_rsp_valid) begin
         check("rsp_timeout", 64'(0), 64'(1));
         return;
      end
      check("latency", 64'(n + 1), 64'(exp_lat));
      for (int i = 0; i < bp; i++) begin
         check("bp_hold", {30'b0, o_rsp_valid, o_req_ready, o_rsp_rd, o_rsp_result},
               {30'b0, 1'b1, 1'b0, rd, exp_res});
         // A competing request must wait for the response handshake.
         i_req_valid = 1'b1;
         i_req_rd    = ~rd;
         @(posedge i_clk);
         @(negedge i_clk);
      end
      check("rsp_result", 64'(o_rsp_result), 64'(exp_res));
      check("rsp_rd", 64'(o_rsp_rd), 64'(rd));
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      i_req_valid = 1'b0;
      check("idle_after_rsp", {62'b0, o_rsp_valid, o_req_ready}, 64'b01);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!o_req_ready && n < 60) begin
         @(posedge i_clk);
         n++;
         @(negedge i_clk);
      end
      check(tag, 64'(o_req_ready), 64'(1));
   endtask

   initial begin
      rice_core_div_operation rop;
      logic [XLEN-1:0] ra, rb;
      int n;

      i_rst_n     = 1'b0;
      i_flush     = 1'b0;
      i_req_valid = 1'b0;
      i_req_rs1   = '0;
      i_req_rs2   = '0;
      i_req_op    = DIV_OP_DIVU;
      i_req_rd    = '0;
      i_rsp_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_state", {61'b0, o_req_ready, o_div_valid, o_rsp_valid}, 64'b100);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("post_reset", {61'b0, o_req_ready, o_div_valid, o_rsp_valid}, 64'b100);

      // Directed results and latency corners.
      run_op(DIV_OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 0, ref_lat(DIV_OP_DIVU, 32'd100) + 1);
      run_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 1, ref_lat(DIV_OP_REM, 32'hFFFF_FFF9) + 1);
      run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000, 0, ref_lat(DIV_OP_DIV, 32'h8000_0000) + 1);
      run_op(DIV_OP_DIVU, 32'd1234, 32'd0, 5'd2, 32'hFFFF_FFFF, 0, ref_lat(DIV_OP_DIVU, 32'd1234) + 1);
      run_op(DIV_OP_DIVU, 32'd0, 32'd5, 5'd4, 32'd0, 0, 4);
      run_op(DIV_OP_DIVU, 32'h8000_0000, 32'd3, 5'd5, 32'h2AAA_AAAA, 0, XLEN + 3);

      // Backpressure for 10 cycles in DONE.
      run_op(DIV_OP_REMU, 32'd1000, 32'd7, 5'd30, 32'd6, 10, ref_lat(DIV_OP_REMU, 32'd1000) + 1);

      // Request presented with flush in IDLE is not taken.
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_flush     = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 1'b0;
      i_flush     = 1'b0;
      check("flush_blocks_req", {62'b0, o_req_ready, o_div_valid}, 64'b10);

      // Flush in BUSY three cycles after accept -> DRAIN, no response.
      accept(DIV_OP_DIVU, 32'h00FF_0000, 32'd3, 5'd7);
      rsp_seen = 0;
      repeat (2) begin
         @(posedge i_clk);
         @(negedge i_clk);
      end
      i_flush = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b0;
      check("drain_div_valid", 64'(o_div_valid), 64'(1));
      wait_idle("drain_to_idle");
      check("drain_no_rsp", 64'(rsp_seen), 64'(0));
      run_op(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd11, 32'hFFFF_FFF2, 0, ref_lat(DIV_OP_DIV, 32'hFFFF_FF9C) + 1);

      // Flush coincident with the divider result.
      accept(DIV_OP_REMU, 32'd77777, 32'd10, 5'd12);
      rsp_seen = 0;
      n = 0;
      while (!i_div_result_valid && n < 60) begin
         @(posedge i_clk);
         n++;
         @(negedge i_clk);
      end
      check("coinc_result_seen", 64'(i_div_result_valid), 64'(1));
      i_flush = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b0;
      check("coinc_idle", {61'b0, o_rsp_valid, o_req_ready, o_div_valid}, 64'b010);
      @(posedge i_clk);
      @(negedge i_clk);
      check("coinc_no_rsp", 64'(rsp_seen), 64'(0));

      // Flush in DONE together with rsp_ready drops the result.
      accept(DIV_OP_DIVU, 32'd50, 32'd5, 5'd13);
      n = 0;
      while (!o_rsp_valid && n < 60) begin
         @(posedge i_clk);
         n++;
         @(negedge i_clk);
      end
      check("done_reached", 64'(o_rsp_valid), 64'(1));
      i_flush     = 1'b1;
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_flush     = 1'b0;
      i_rsp_ready = 1'b0;
      check("done_flush_idle", {62'b0, o_rsp_valid, o_req_ready}, 64'b01);

      // Asynchronous reset while BUSY.
      accept(DIV_OP_DIVU, 32'hFFFF_0000, 32'd9, 5'd14);
      @(posedge i_clk);
      @(negedge i_clk);
      check("busy_before_rst", 64'(o_div_valid), 64'(1));
      #2 i_rst_n = 1'b0;
      #1 check("async_rst", {61'b0, o_req_ready, o_div_valid, o_rsp_valid}, 64'b100);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run_op(DIV_OP_REMU, 32'd99, 32'd10, 5'd15, 32'd9, 0, ref_lat(DIV_OP_REMU, 32'd99) + 1);

      // Randomized operations with random backpressure.
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       rop = DIV_OP_DIV;
            1:       rop = DIV_OP_DIVU;
            2:       rop = DIV_OP_REM;
            default: rop = DIV_OP_REMU;
         endcase
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: rb = XLEN'($urandom_range(1, 20));
            4: ra = XLEN'($urandom_range(0, 300));
            default: ;
         endcase
         run_op(rop, ra, rb, TAG_WIDTH'($urandom), ref_div(rop, ra, rb),
                $urandom_range(0, 3), ref_lat(rop, ra) + 1);
      end

      @(negedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
